// File: rtl/mc_control_unit_pkg.sv
// ============================================================================
// Module  : mc_control_unit_pkg
// Brief   : Shared opcodes, ula32 codes, mux selects and FSM state encodings
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_control_unit_pkg;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_and = 6'h24;

  localparam logic [2:0] c_ula_load = 3'b000;
  localparam logic [2:0] c_ula_add  = 3'b001;
  localparam logic [2:0] c_ula_sub  = 3'b010;
  localparam logic [2:0] c_ula_and  = 3'b011;

  localparam logic [1:0] c_selb_reg     = 2'b00;
  localparam logic [1:0] c_selb_four    = 2'b01;
  localparam logic [1:0] c_selb_sext    = 2'b10;
  localparam logic [1:0] c_selb_sext_sh = 2'b11;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_R_EXEC  = 4'd3,
    S_R_WB    = 4'd4,
    S_ADDR    = 4'd5,
    S_ADDI_WB = 4'd6,
    S_MEM_RD  = 4'd7,
    S_LW_WB   = 4'd8,
    S_MEM_WR  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    CLS_LOAD  = 2'd0,
    CLS_ADD   = 2'd1,
    CLS_SUB   = 2'd2,
    CLS_RTYPE = 2'd3
  } alu_cls_e;

endpackage

`default_nettype wire

// File: rtl/mc_control_unit_if.sv
// ============================================================================
// Module  : mc_control_unit_if
// Brief   : Decode inputs and datapath control outputs of the controller
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_control_unit_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ula_zero;
  logic       ula_overflow;
  logic       pc_write;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       mdr_write;
  logic       ab_write;
  logic       aluout_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       sel_ula_A;
  logic [1:0] sel_ula_B;
  logic [2:0] ula_func;
  logic [1:0] pc_source;
  logic       trap;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct, ula_zero, ula_overflow,
    output pc_write, iord, mem_write, ir_write, mdr_write, ab_write,
           aluout_write, reg_write, reg_dst, mem_to_reg, sel_ula_A,
           sel_ula_B, ula_func, pc_source, trap, state_dbg
  );

  modport slave (
    output opcode, funct, ula_zero, ula_overflow,
    input  pc_write, iord, mem_write, ir_write, mdr_write, ab_write,
           aluout_write, reg_write, reg_dst, mem_to_reg, sel_ula_A,
           sel_ula_B, ula_func, pc_source, trap, state_dbg
  );
endinterface

`default_nettype wire

// File: rtl/mc_control_unit_alu_ctrl.sv
// ============================================================================
// Module  : mc_control_unit_alu_ctrl
// Brief   : Maps the state's ALU class and funct to a ula32 operation
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_unit_alu_ctrl
  import mc_control_unit_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] funct_i,
  output logic [2:0] ula_func_o,
  output logic       funct_valid_o
);

  always_comb begin
    ula_func_o    = c_ula_load;
    funct_valid_o = 1'b1;
    case (cls_i)
      CLS_ADD: ula_func_o = c_ula_add;
      CLS_SUB: ula_func_o = c_ula_sub;
      CLS_RTYPE: begin
        case (funct_i)
          c_fn_add: ula_func_o = c_ula_add;
          c_fn_sub: ula_func_o = c_ula_sub;
          c_fn_and: ula_func_o = c_ula_and;
          default:  funct_valid_o = 1'b0;
        endcase
      end
      default: ula_func_o = c_ula_load;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_unit.sv
// ============================================================================
// Module  : mc_control_unit
// Brief   : Multicycle CPU control FSM with memory wait counter and trap
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int WAIT_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  mc_control_unit_if.master bus
);

  if ((MEM_WAIT < 0) || (MEM_WAIT > (2 ** WAIT_W) - 1)) begin : g_mem_wait_check
    $error("MEM_WAIT does not fit in WAIT_W bits");
  end

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              trap_q, trap_d;

  alu_cls_e   alu_cls;
  logic [2:0] ula_func;
  logic       funct_valid;
  logic       last_wait;
  logic       pc_write_raw, mem_write_raw, ir_write_raw, mdr_write_raw;
  logic       ab_write_raw, aluout_write_raw, reg_write_raw;
  logic       iord, reg_dst, mem_to_reg, sel_ula_a;
  logic [1:0] sel_ula_b, pc_source;

  mc_control_unit_alu_ctrl u_alu_ctrl (
    .cls_i         (alu_cls),
    .funct_i       (bus.funct),
    .ula_func_o    (ula_func),
    .funct_valid_o (funct_valid)
  );

  assign last_wait = (wait_q == WAIT_W'(MEM_WAIT));
  assign trap_d    = trap_q | (state_d == S_TRAP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RST;
      wait_q  <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    wait_d           = '0;
    alu_cls          = CLS_LOAD;
    pc_write_raw     = 1'b0;
    mem_write_raw    = 1'b0;
    ir_write_raw     = 1'b0;
    mdr_write_raw    = 1'b0;
    ab_write_raw     = 1'b0;
    aluout_write_raw = 1'b0;
    reg_write_raw    = 1'b0;
    iord             = 1'b0;
    reg_dst          = 1'b0;
    mem_to_reg       = 1'b0;
    sel_ula_a        = 1'b0;
    sel_ula_b        = c_selb_reg;
    pc_source        = c_pcsrc_alu;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        sel_ula_a = 1'b1;
        sel_ula_b = c_selb_four;
        alu_cls   = CLS_ADD;
        if (last_wait) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          state_d      = S_DECODE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        sel_ula_a        = 1'b1;
        sel_ula_b        = c_selb_sext_sh;
        alu_cls          = CLS_ADD;
        aluout_write_raw = 1'b1;
        ab_write_raw     = 1'b1;
        case (bus.opcode)
          c_op_rtype:                   state_d = S_R_EXEC;
          c_op_addi, c_op_lw, c_op_sw:  state_d = S_ADDR;
          c_op_beq, c_op_bne:           state_d = S_BRANCH;
          c_op_j:                       state_d = S_JUMP;
          default:                      state_d = S_TRAP;
        endcase
      end
      S_R_EXEC: begin
        alu_cls          = CLS_RTYPE;
        aluout_write_raw = 1'b1;
        // The and operation cannot overflow, so only add/sub may trap on it
        if (!funct_valid || (bus.ula_overflow && (ula_func != c_ula_and)))
          state_d = S_TRAP;
        else
          state_d = S_R_WB;
      end
      S_R_WB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDR: begin
        sel_ula_b        = c_selb_sext;
        alu_cls          = CLS_ADD;
        aluout_write_raw = 1'b1;
        case (bus.opcode)
          c_op_lw: state_d = S_MEM_RD;
          c_op_sw: state_d = S_MEM_WR;
          default: state_d = bus.ula_overflow ? S_TRAP : S_ADDI_WB;
        endcase
      end
      S_ADDI_WB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEM_RD: begin
        iord = 1'b1;
        if (last_wait) begin
          mdr_write_raw = 1'b1;
          state_d       = S_LW_WB;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_LW_WB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEM_WR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_cls      = CLS_SUB;
        pc_source    = c_pcsrc_aluout;
        pc_write_raw = (bus.opcode == c_op_bne) ? !bus.ula_zero : bus.ula_zero;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pc_source    = c_pcsrc_jump;
        pc_write_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_RST;
    endcase
  end

  // Gating with reset keeps a mid-instruction reset from committing anything
  assign bus.pc_write     = pc_write_raw & reset;
  assign bus.mem_write    = mem_write_raw & reset;
  assign bus.ir_write     = ir_write_raw & reset;
  assign bus.mdr_write    = mdr_write_raw & reset;
  assign bus.ab_write     = ab_write_raw & reset;
  assign bus.aluout_write = aluout_write_raw & reset;
  assign bus.reg_write    = reg_write_raw & reset;
  assign bus.iord         = iord;
  assign bus.reg_dst      = reg_dst;
  assign bus.mem_to_reg   = mem_to_reg;
  assign bus.sel_ula_A    = sel_ula_a;
  assign bus.sel_ula_B    = sel_ula_b;
  assign bus.ula_func     = ula_func;
  assign bus.pc_source    = pc_source;
  assign bus.trap         = trap_q;
  assign bus.state_dbg    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// ============================================================================
// Module  : tb_mc_control_unit
// Brief   : Instruction-level model checks two controllers (MEM_WAIT 1 and 2)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control_unit;
  import mc_control_unit_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       aluout_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       sel_a;
    logic [1:0] sel_b;
    logic [2:0] func;
    logic [1:0] pc_src;
    logic       trap;
    logic [3:0] state;
  } outs_t;

  logic       clk;
  logic       rst_a  [2];
  logic [5:0] op_a   [2];
  logic [5:0] fn_a   [2];
  logic       ovf_a  [2];
  logic       zero_a [2];

  mc_control_unit_if ifc0 ();
  mc_control_unit_if ifc1 ();

  assign ifc0.opcode = op_a[0];
  assign ifc0.funct = fn_a[0];
  assign ifc0.ula_overflow = ovf_a[0];
  assign ifc0.ula_zero = zero_a[0];
  assign ifc1.opcode = op_a[1];
  assign ifc1.funct = fn_a[1];
  assign ifc1.ula_overflow = ovf_a[1];
  assign ifc1.ula_zero = zero_a[1];

  mc_control_unit #(.MEM_WAIT(1), .WAIT_W(3)) u_dut0 (.clk(clk), .reset(rst_a[0]), .bus(ifc0));
  mc_control_unit #(.MEM_WAIT(2), .WAIT_W(3)) u_dut1 (.clk(clk), .reset(rst_a[1]), .bus(ifc1));

  outs_t act0, act1;
  assign act0 = {ifc0.pc_write, ifc0.iord, ifc0.mem_write, ifc0.ir_write, ifc0.mdr_write,
                 ifc0.ab_write, ifc0.aluout_write, ifc0.reg_write, ifc0.reg_dst,
                 ifc0.mem_to_reg, ifc0.sel_ula_A, ifc0.sel_ula_B, ifc0.ula_func,
                 ifc0.pc_source, ifc0.trap, ifc0.state_dbg};
  assign act1 = {ifc1.pc_write, ifc1.iord, ifc1.mem_write, ifc1.ir_write, ifc1.mdr_write,
                 ifc1.ab_write, ifc1.aluout_write, ifc1.reg_write, ifc1.reg_dst,
                 ifc1.mem_to_reg, ifc1.sel_ula_A, ifc1.sel_ula_B, ifc1.ula_func,
                 ifc1.pc_source, ifc1.trap, ifc1.state_dbg};

  outs_t expq0[$];
  outs_t expq1[$];
  int    latq0[$];
  int    latq1[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    done0 = 1'b0;
  bit    done1 = 1'b0;

  // Instruction latencies (FETCH entry to next FETCH entry) for the first 11 instructions
  int lat_lit0 [11] = '{5, 7, 5, 4, 4, 4, 4, 4, 5, 5, 5};
  int lat_lit1 [11] = '{6, 9, 6, 5, 5, 5, 5, 5, 6, 6, 6};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t vec(input state_e s);
    outs_t v;
    v = '0;
    v.state = s;
    return v;
  endfunction

  function automatic outs_t mask(input outs_t v);
    outs_t m;
    m = v;
    m.pc_write = 1'b0;
    m.mem_write = 1'b0;
    m.ir_write = 1'b0;
    m.mdr_write = 1'b0;
    m.ab_write = 1'b0;
    m.aluout_write = 1'b0;
    m.reg_write = 1'b0;
    return m;
  endfunction

  task automatic check(input int k, input outs_t a, input outs_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL cycle_vector dut%0d t=%0t state=%0d: got %h required %h",
               k, $time, e.state, a, e);
    end
  endtask

  task automatic step(input int k, input outs_t e);
    if (k == 0) expq0.push_back(e);
    else        expq1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Builds the full expected cycle list of one instruction, then plays it
  task automatic instr(input int k, input int mw, input logic [5:0] op, input logic [5:0] fn,
                       input logic ovf, input logic zero, input int rst_at);
    outs_t seq[$];
    outs_t v;
    bit    trapped;
    trapped = 1'b0;
    op_a[k] = op; fn_a[k] = fn; ovf_a[k] = ovf; zero_a[k] = zero;
    for (int i = 0; i <= mw; i++) begin
      v = vec(S_FETCH); v.sel_a = 1'b1; v.sel_b = 2'b01; v.func = 3'b001;
      if (i == mw) begin v.ir_write = 1'b1; v.pc_write = 1'b1; end
      seq.push_back(v);
    end
    v = vec(S_DECODE); v.sel_a = 1'b1; v.sel_b = 2'b11; v.func = 3'b001;
    v.aluout_write = 1'b1; v.ab_write = 1'b1;
    seq.push_back(v);
    case (op)
      6'h00: begin
        v = vec(S_R_EXEC); v.aluout_write = 1'b1;
        v.func = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b000;
        seq.push_back(v);
        if (v.func == 3'b000 || (ovf && fn != 6'h24)) trapped = 1'b1;
        else begin v = vec(S_R_WB); v.reg_dst = 1'b1; v.reg_write = 1'b1; seq.push_back(v); end
      end
      6'h08, 6'h23, 6'h2B: begin
        v = vec(S_ADDR); v.sel_b = 2'b10; v.func = 3'b001; v.aluout_write = 1'b1;
        seq.push_back(v);
        if (op == 6'h23) begin
          for (int i = 0; i <= mw; i++) begin
            v = vec(S_MEM_RD); v.iord = 1'b1; v.mdr_write = (i == mw);
            seq.push_back(v);
          end
          v = vec(S_LW_WB); v.mem_to_reg = 1'b1; v.reg_write = 1'b1; seq.push_back(v);
        end else if (op == 6'h2B) begin
          v = vec(S_MEM_WR); v.iord = 1'b1; v.mem_write = 1'b1; seq.push_back(v);
        end else if (ovf) begin
          trapped = 1'b1;
        end else begin
          v = vec(S_ADDI_WB); v.reg_write = 1'b1; seq.push_back(v);
        end
      end
      6'h04, 6'h05: begin
        v = vec(S_BRANCH); v.func = 3'b010; v.pc_src = 2'b01;
        v.pc_write = (op == 6'h04) ? zero : !zero;
        seq.push_back(v);
      end
      6'h02: begin
        v = vec(S_JUMP); v.pc_src = 2'b10; v.pc_write = 1'b1; seq.push_back(v);
      end
      default: trapped = 1'b1;
    endcase
    if (trapped) begin
      for (int i = 0; i < 10; i++) begin
        v = vec(S_TRAP); v.trap = 1'b1; seq.push_back(v);
      end
    end
    for (int i = 0; i < seq.size(); i++) begin
      if (i == rst_at) begin
        rst_a[k] = 1'b0;
        step(k, mask(seq[i]));
        step(k, vec(S_RST));
        rst_a[k] = 1'b1;
        step(k, vec(S_RST));
        return;
      end
      step(k, seq[i]);
    end
  endtask

  task automatic reset_from_trap(input int k);
    outs_t v;
    v = vec(S_TRAP); v.trap = 1'b1;
    rst_a[k] = 1'b0;
    step(k, v);
    rst_a[k] = 1'b1;
    step(k, vec(S_RST));
  endtask

  task automatic run(input int k, input int mw);
    rst_a[k] = 1'b0; op_a[k] = '0; fn_a[k] = '0; ovf_a[k] = 1'b0; zero_a[k] = 1'b0;
    @(posedge clk);
    #1;
    step(k, vec(S_RST));
    step(k, vec(S_RST));
    rst_a[k] = 1'b1;
    step(k, vec(S_RST));
    instr(k, mw, 6'h00, 6'h20, 1'b0, 1'b0, -1);
    instr(k, mw, 6'h23, 6'h00, 1'b0, 1'b0, -1);
    instr(k, mw, 6'h2B, 6'h00, 1'b0, 1'b0, -1);
    instr(k, mw, 6'h04, 6'h00, 1'b0, 1'b1, -1);
    instr(k, mw, 6'h04, 6'h00, 1'b0, 1'b0, -1);
    instr(k, mw, 6'h05, 6'h00, 1'b0, 1'b1, -1);
    instr(k, mw, 6'h05, 6'h00, 1'b0, 1'b0, -1);
    instr(k, mw, 6'h02, 6'h00, 1'b0, 1'b0, -1);
    instr(k, mw, 6'h00, 6'h22, 1'b0, 1'b0, -1);
    instr(k, mw, 6'h00, 6'h24, 1'b1, 1'b0, -1);
    instr(k, mw, 6'h08, 6'h00, 1'b0, 1'b0, -1);
    instr(k, mw, 6'h00, 6'h20, 1'b1, 1'b0, -1);
    reset_from_trap(k);
    instr(k, mw, 6'h3F, 6'h00, 1'b0, 1'b0, -1);
    reset_from_trap(k);
    instr(k, mw, 6'h08, 6'h00, 1'b1, 1'b0, -1);
    reset_from_trap(k);
    instr(k, mw, 6'h00, 6'h21, 1'b0, 1'b0, -1);
    reset_from_trap(k);
    instr(k, mw, 6'h23, 6'h00, 1'b1, 1'b0, -1);
    instr(k, mw, 6'h2B, 6'h00, 1'b0, 1'b0, mw + 3);
    instr(k, mw, 6'h02, 6'h00, 1'b0, 1'b0, -1);
  endtask

  initial begin
    int    cyc;
    int    last0, last1;
    logic [3:0] prev0, prev1;
    cyc = 0; last0 = -1; last1 = -1; prev0 = '0; prev1 = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq0.size() > 0) check(0, act0, expq0.pop_front());
      if (expq1.size() > 0) check(1, act1, expq1.pop_front());
      if (act0.state == 4'(S_FETCH) && prev0 != 4'(S_FETCH)) begin
        if (last0 >= 0) latq0.push_back(cyc - last0);
        last0 = cyc;
      end
      if (act1.state == 4'(S_FETCH) && prev1 != 4'(S_FETCH)) begin
        if (last1 >= 0) latq1.push_back(cyc - last1);
        last1 = cyc;
      end
      prev0 = act0.state;
      prev1 = act1.state;
    end
  end

  initial begin
    int got;
    fork
      begin run(0, 1); done0 = 1'b1; end
      begin run(1, 2); done1 = 1'b1; end
    join_none
    for (int t = 0; t < 5000 && !(done0 && done1); t++) @(posedge clk);
    if (!(done0 && done1)) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: drivers done=%0b%0b required 11", done0, done1);
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      got = (latq0.size() > i) ? latq0[i] : -1;
      if (got != lat_lit0[i]) begin
        n_fail++;
        $display("FAIL latency dut0 instr%0d: got %0d required %0d", i, got, lat_lit0[i]);
      end
      n_checks++;
      got = (latq1.size() > i) ? latq1[i] : -1;
      if (got != lat_lit1[i]) begin
        n_fail++;
        $display("FAIL latency dut1 instr%0d: got %0d required %0d", i, got, lat_lit1[i]);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
